ps2_player_dispatcher: RTL
==========================

# ps2_player_dispatcher

Sits between the PS2 keyboard interface and the two player processors. It parses the raw scancode byte stream (make, break and E0-extended codes) and maps player 1 letter keys and player 2 arrow keys to arrow codes. Per-player FIFOs absorb keyboard bursts, and held-key auto-repeat is suppressed. Events are delivered to each processor as one-cycle key pulses at a guaranteed minimum spacing, and a one-cycle game-reset request is raised on the reset key.

## Interface
- FIFO_DEPTH, 4: entries per player queue; power of two, ≥2.
- HOLDOFF, 16: minimum clock cycles between consecutive key pulses of one player; ≥1.
- clock  in  1  system clock (PLL-divided clock domain of the processors).
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ps2_key_pressed  in  1  one-cycle strobe, ps2_key_data valid.
- ps2_key_data  in  8  raw scancode byte.
- p1_key_pressed  out  1  one-cycle event pulse to player 1 processor.
- p1_arrow_input  out  8  {5'b0, code}; code 1=up, 2=left, 3=down, 4=right.
- p2_key_pressed  out  1  as p1, for player 2.
- p2_arrow_input  out  8  as p1, for player 2.
- game_reset_req  out  1  one-cycle pulse on reset-key make code.
- p1_overflow, p2_overflow  out  1 each  sticky drop flag; cleared only by reset.

## Operation
- Byte consumed only on a cycle with ps2_key_pressed=1. Otherwise the FSM holds.
- Prefix FSM states: IDLE, EXT, BRK, EXT_BRK.
  - IDLE: E0→EXT; F0→BRK; any other byte is a normal make code, stay IDLE.
  - EXT: F0→EXT_BRK; E0 stays EXT; any other byte is an extended make code →IDLE.
  - BRK: any byte is a normal break code →IDLE.
  - EXT_BRK: any byte is an extended break code →IDLE.
- Normal make codes:
  - 1D→p1 code 1, 1C→2, 1B→3, 23→4.
  - 2D→game_reset_req.
  - Others ignored.
- Extended make codes: 75→p2 code 1, 6B→2, 72→3, 74→4. Others ignored.
- Player 2 keys without an E0 prefix are ignored.
- Held-key register per player: 3 bits, 0 = none.
  - A mapped make code equal to the held code is dropped (typematic repeat).
  - A different mapped make code is accepted and becomes the held code.
- Break codes: a normal break of p1's held key clears p1 held; an extended break of p2's held key clears p2 held. Other breaks are ignored.
- Accepted event is pushed to that player's FIFO.
- If the FIFO is full and no pop occurs that cycle: the event is dropped, pX_overflow←1, and the held register is still updated.
- Push and pop in the same cycle are always legal; when full, such a push is accepted.
- Scheduler per player, with down-counter hold (range 0..HOLDOFF-1):
  - When hold=0 and FIFO non-empty: pop, pX_key_pressed=1 for one cycle, pX_arrow_input←popped code, hold←HOLDOFF-1.
  - When hold≠0: decrement.
- pX_arrow_input is registered and keeps the last popped value between pulses.
- The two players are fully independent and may pulse in the same cycle.
- 2D make pulses game_reset_req every time; no repeat suppression. Break of 2D has no effect.

## Timing
- Reset values: all outputs 0, FSM IDLE, FIFOs empty, hold counters 0, held registers 0. Reset asserted mid-operation discards queued events at once.
- Latency: strobe sampled at edge k → entry in FIFO after edge k → pX_key_pressed high in the cycle following edge k+1, when FIFO was empty and hold=0.
- game_reset_req is high in the cycle after edge k.
- Consecutive pulses of one player are exactly HOLDOFF cycles apart while the FIFO is non-empty. HOLDOFF=1 gives back-to-back pulses.
- Full throughput: one byte per cycle accepted.

## Test plan
- Byte 1D → p1_key_pressed one cycle, 2 edges after strobe, p1_arrow_input=8'h01; p2 outputs stay 0.
- E0,75 → p2 pulse, code 1. Then E0,F0,75 → no pulse. Then E0,75 → second p2 pulse code 1. Plain 75 → no pulse.
- Repeat suppression: 1C,1C,1C → exactly one p1 pulse, code 2. Then F0,1C,1C → second pulse, code 2.
- Burst with HOLDOFF=16, FIFO_DEPTH=4: bytes 1D,1C,1B,23,1D,1C on consecutive cycles → p1 pulses with codes 1,2,3,4,1, exactly 16 cycles apart. The last 1C is dropped and p1_overflow=1.
- 2D → game_reset_req high exactly one cycle. F0,2D → none. Interleaved 1D and E0,6B → both players pulse independently, codes 1 and 2.
- Assert reset mid-burst (3 entries queued) → all outputs 0 asynchronously, overflow cleared. After release, no stale pulses; a new 1B gives a single code 3 pulse.

Source files
------------

// File: rtl/ps2_player_dispatcher.sv
// Scancode parser and two-player key dispatcher: maps PS2 make/break codes to arrow
// codes, queues them per player, suppresses typematic repeat and paces key pulses.
module ps2_player_dispatcher #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned HOLDOFF    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ps2_key_pressed,
   input  logic [7:0] ps2_key_data,
   output logic       p1_key_pressed,
   output logic [7:0] p1_arrow_input,
   output logic       p2_key_pressed,
   output logic [7:0] p2_arrow_input,
   output logic       game_reset_req,
   output logic       p1_overflow,
   output logic       p2_overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLDOFF - 1);
   localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_e;

   state_e        state_q, state_d;
   logic          grr_q, grr_d;
   logic [2:0]    mem_q   [2][FIFO_DEPTH];
   logic [2:0]    mem_d   [2][FIFO_DEPTH];
   logic [AW:0]   wr_q    [2];
   logic [AW:0]   wr_d    [2];
   logic [AW:0]   rd_q    [2];
   logic [AW:0]   rd_d    [2];
   logic [HW-1:0] hold_q  [2];
   logic [HW-1:0] hold_d  [2];
   logic [2:0]    held_q  [2];
   logic [2:0]    held_d  [2];
   logic [2:0]    arrow_q [2];
   logic [2:0]    arrow_d [2];
   logic          pulse_q [2];
   logic          pulse_d [2];
   logic          ovf_q   [2];
   logic          ovf_d   [2];
   logic [2:0]    make_code [2];
   logic [2:0]    brk_code  [2];

   function automatic logic [2:0] p1_map(input logic [7:0] b);
      case (b)
         8'h1D:   return 3'd1;
         8'h1C:   return 3'd2;
         8'h1B:   return 3'd3;
         8'h23:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [2:0] p2_map(input logic [7:0] b);
      case (b)
         8'h75:   return 3'd1;
         8'h6B:   return 3'd2;
         8'h72:   return 3'd3;
         8'h74:   return 3'd4;
         default: return 3'd0;
      endcase
   endfunction

   // Prefix parser: a zero code means "no event for that player this cycle".
   always_comb begin
      state_d   = state_q;
      grr_d     = 1'b0;
      make_code = '{default: '0};
      brk_code  = '{default: '0};
      if (ps2_key_pressed) begin
         case (state_q)
            IDLE: begin
               if (ps2_key_data == 8'hE0) begin
                  state_d = EXT;
               end else if (ps2_key_data == 8'hF0) begin
                  state_d = BRK;
               end else begin
                  make_code[0] = p1_map(ps2_key_data);
                  grr_d        = (ps2_key_data == 8'h2D);
               end
            end
            EXT: begin
               if (ps2_key_data == 8'hF0) begin
                  state_d = EXT_BRK;
               end else if (ps2_key_data != 8'hE0) begin
                  make_code[1] = p2_map(ps2_key_data);
                  state_d      = IDLE;
               end
            end
            BRK: begin
               brk_code[0] = p1_map(ps2_key_data);
               state_d     = IDLE;
            end
            EXT_BRK: begin
               brk_code[1] = p2_map(ps2_key_data);
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Pop is decided first so a push into a full queue can use the slot freed this cycle.
   always_comb begin
      logic pop, full, push_req;
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      hold_d  = hold_q;
      held_d  = held_q;
      arrow_d = arrow_q;
      ovf_d   = ovf_q;
      pulse_d = '{default: 1'b0};
      for (int unsigned p = 0; p < 2; p++) begin
         pop      = (hold_q[p] == '0) && (wr_q[p] != rd_q[p]);
         full     = ((wr_q[p] - rd_q[p]) == DEPTH_CNT);
         push_req = (make_code[p] != '0) && (make_code[p] != held_q[p]);

         if (push_req) begin
            held_d[p] = make_code[p];
         end
         if ((brk_code[p] != '0) && (brk_code[p] == held_q[p])) begin
            held_d[p] = '0;
         end

         if (pop) begin
            pulse_d[p] = 1'b1;
            arrow_d[p] = mem_q[p][rd_q[p][AW-1:0]];
            rd_d[p]    = rd_q[p] + 1'b1;
            hold_d[p]  = HOLD_RELOAD;
         end else if (hold_q[p] != '0) begin
            hold_d[p] = hold_q[p] - 1'b1;
         end

         if (push_req) begin
            if (!full || pop) begin
               mem_d[p][wr_q[p][AW-1:0]] = make_code[p];
               wr_d[p] = wr_q[p] + 1'b1;
            end else begin
               ovf_d[p] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grr_q   <= 1'b0;
         mem_q   <= '{default: '{default: '0}};
         wr_q    <= '{default: '0};
         rd_q    <= '{default: '0};
         hold_q  <= '{default: '0};
         held_q  <= '{default: '0};
         arrow_q <= '{default: '0};
         pulse_q <= '{default: 1'b0};
         ovf_q   <= '{default: 1'b0};
      end else begin
         state_q <= state_d;
         grr_q   <= grr_d;
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         hold_q  <= hold_d;
         held_q  <= held_d;
         arrow_q <= arrow_d;
         pulse_q <= pulse_d;
         ovf_q   <= ovf_d;
      end
   end

   assign p1_key_pressed = pulse_q[0];
   assign p2_key_pressed = pulse_q[1];
   assign p1_arrow_input = {5'b0, arrow_q[0]};
   assign p2_arrow_input = {5'b0, arrow_q[1]};
   assign p1_overflow    = ovf_q[0];
   assign p2_overflow    = ovf_q[1];
   assign game_reset_req = grr_q;

endmodule
